// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the image accelerator, its memory
// model and bench. Holds the sequencing FSM state enum, pixel geometry and the
// default frame size / write-back offset for a 352x288 8-bit image.
`timescale 1ns/1ps
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned PIX_PER_WORD   = 4;
  localparam int unsigned DEF_IMG_WORDS  = (352 * 288) / PIX_PER_WORD;
  localparam int unsigned DEF_OUT_OFFSET = DEF_IMG_WORDS;

endpackage

// File: rtl/pixel_xform.sv
// pixel_xform: combinational per-lane pixel transform on one memory word.
// Default build inverts each 8-bit lane (255-p). With ACC_THRESHOLD_EN defined,
// each lane becomes 8'hFF when its inverse is >= THRESH, else 8'h00.
// Ports:
//   din  in  DATA_W  packed input pixels
//   dout out DATA_W  packed transformed pixels
`timescale 1ns/1ps
module pixel_xform
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned THRESH = 128
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

`ifdef ACC_THRESHOLD_EN
  localparam bit USE_THRESH = 1'b1;
`else
  localparam bit USE_THRESH = 1'b0;
`endif

  localparam int unsigned LANES = DATA_W / PIX_W;

  // Lanes are independent: subtraction from all-ones never borrows.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] inv;
    logic [PIX_W-1:0] thr;
    assign inv = {PIX_W{1'b1}} - din[i*PIX_W +: PIX_W];
    assign thr = (32'(inv) >= THRESH) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    assign dout[i*PIX_W +: PIX_W] = USE_THRESH ? thr : inv;
  end

endmodule

// File: rtl/acc_invert.sv
// acc_invert: memory-mapped image accelerator. On start it reads each input
// word, transforms it with pixel_xform and writes the result OUT_OFFSET words
// higher, two cycles per word on a single-port memory, then raises finish
// until start is dropped.
// Optional feature: ACC_THRESHOLD_EN (binarised output, handled in pixel_xform).
// Ports:
//   clk    in   1       clock, rising edge
//   reset  in   1       asynchronous active-low reset
//   addr   out  ADDR_W  memory word address
//   dataR  in   DATA_W  memory read data, valid the cycle after a read
//   dataW  out  DATA_W  memory write data
//   en     out  1       memory access enable
//   we     out  1       memory write enable
//   start  in   1       level request
//   finish out  1       frame complete
`timescale 1ns/1ps
module acc_invert
  import acc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMG_WORDS  = DEF_IMG_WORDS,
  parameter int unsigned OUT_OFFSET = DEF_OUT_OFFSET,
  parameter int unsigned THRESH     = 128
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataR,
  output logic [DATA_W-1:0] dataW,
  output logic              en,
  output logic              we,
  input  logic              start,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFFSET    = ADDR_W'(OUT_OFFSET);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] xf_data;

  pixel_xform #(
    .DATA_W (DATA_W),
    .THRESH (THRESH)
  ) u_xform (
    .din  (dataR),
    .dout (xf_data)
  );

  // State and word counter; reset forces IDLE so all decoded outputs drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore-decoded memory interface.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en      = 1'b0;
    we      = 1'b0;
    addr    = '0;
    dataW   = '0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = READ;
      end
      READ: begin
        en      = 1'b1;
        addr    = cnt_q;
        state_d = WRITE;
      end
      WRITE: begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = cnt_q + OFFSET;
        dataW = xf_data;
        if (cnt_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = READ;
        end
      end
      DONE: begin
        finish = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_invert.sv
// tb_acc_invert: directed bench for acc_invert on a 4-word frame with a
// behavioural single-port memory. Checks reset state, access sequence and
// latency, write-back data, start/finish handshake and mid-frame reset.
`timescale 1ns/1ps
module tb_acc_invert;

  localparam int unsigned IMG = 4;
  localparam int unsigned OFF = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] addr;
  logic [31:0] dataR, dataW;
  logic        en, we, finish;

  logic [31:0] mem [0:255];
  logic [31:0] rd_q  = '0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a  = '0;
  logic [31:0] ld_d  = '0;
  int          acc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          base;

  logic [31:0] in_a [4] = '{32'h00FF7F80, 32'h01020304, 32'hFFFFFFFF, 32'h00000000};
  logic [31:0] in_b [4] = '{32'h807F00FF, 32'h12345678, 32'hAA55C33C, 32'h80808080};
`ifdef ACC_THRESHOLD_EN
  logic [31:0] exp_a [4] = '{32'hFF00FF00, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
  logic [31:0] exp_b [4] = '{32'h00FFFF00, 32'hFFFFFFFF, 32'h00FF00FF, 32'h00000000};
`else
  logic [31:0] exp_a [4] = '{32'hFF00807F, 32'hFEFDFCFB, 32'h00000000, 32'hFFFFFFFF};
  logic [31:0] exp_b [4] = '{32'h7F80FF00, 32'hEDCBA987, 32'h55AA3CC3, 32'h7F7F7F7F};
`endif

  always #5 clk = ~clk;

  acc_invert #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .IMG_WORDS  (IMG),
    .OUT_OFFSET (OFF),
    .THRESH     (128)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .dataR  (dataR),
    .dataW  (dataW),
    .en     (en),
    .we     (we),
    .start  (start),
    .finish (finish)
  );

  // Single-port synchronous memory with a bench-side load port.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_a] <= ld_d;
    end else if (en) begin
      acc_cnt <= acc_cnt + 1;
      if (we) mem[addr[7:0]] <= dataW;
      else    rd_q <= mem[addr[7:0]];
    end
  end
  assign dataR = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Start a frame and check every access cycle; optionally drop start after
  // the first cycle, or assert reset in access cycle abort_at.
  task automatic run_frame(input bit hold, input int abort_at);
    logic [31:0] ea;
    @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= 2 * IMG; j++) begin
      @(negedge clk);
      if (!hold && j == 1) start = 1'b0;
      ea = (j % 2 == 1) ? 32'((j - 1) / 2) : 32'(OFF + j / 2 - 1);
      check("acc_en",     32'(en),     32'd1);
      check("acc_we",     32'(we),     32'(j % 2 == 0));
      check("acc_addr",   32'(addr),   ea);
      check("acc_finish", 32'(finish), 32'd0);
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        check("rst_en",     32'(en),     32'd0);
        check("rst_we",     32'(we),     32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_addr",   32'(addr),   32'd0);
        check("rst_dataW",  dataW,       32'd0);
        return;
      end
    end
    @(negedge clk);
    check("done_finish", 32'(finish), 32'd1);
    check("done_en",     32'(en),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_en",     32'(en),     32'd0);
    check("reset_we",     32'(we),     32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    check("reset_addr",   32'(addr),   32'd0);
    check("reset_dataW",  dataW,       32'd0);
    reset = 1'b1;

    // Frame A, start held through completion
    for (int i = 0; i < 4; i++) load(8'(i), in_a[i]);
    for (int i = 0; i < 4; i++) load(8'(OFF + i), 32'hDEADBEEF);
    base = acc_cnt;
    run_frame(1'b1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_finish", 32'(finish), 32'd1);
      check("hold_en",     32'(en),     32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_finish", 32'(finish), 32'd0);
    @(negedge clk);
    check("idle_en", 32'(en), 32'd0);
    check("a_accesses", 32'(acc_cnt - base), 32'd8);
    for (int i = 0; i < 4; i++) check("a_data", mem[OFF + i], exp_a[i]);

    // Frame B aborted by reset during the write of word 2
    for (int i = 0; i < 4; i++) load(8'(i), in_b[i]);
    for (int i = 0; i < 4; i++) load(8'(OFF + i), 32'hA5A5A5A5);
    base = acc_cnt;
    run_frame(1'b1, 6);
    @(negedge clk);
    check("rst_hold_en", 32'(en), 32'd0);
    check("rst_accesses", 32'(acc_cnt - base), 32'd5);
    check("rst_word0", mem[OFF + 0], exp_b[0]);
    check("rst_word1", mem[OFF + 1], exp_b[1]);
    check("rst_word2", mem[OFF + 2], 32'hA5A5A5A5);
    check("rst_word3", mem[OFF + 3], 32'hA5A5A5A5);
    start = 1'b0;
    reset = 1'b1;

    // Frame B rerun with start pulsed: frame must still complete
    base = acc_cnt;
    run_frame(1'b0, 0);
    @(negedge clk);
    check("pulse_idle_finish", 32'(finish), 32'd0);
    check("b_accesses", 32'(acc_cnt - base), 32'd8);
    for (int i = 0; i < 4; i++) check("b_data", mem[OFF + i], exp_b[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
